// File: rtl/cache_writeback_buffer.sv
// cache_writeback_buffer: posted-write victim buffer between the cache and main memory.
// Evicted blocks are queued and drained to memory in FIFO order, one transaction
// held for mem_latency cycles; block fetches hit the queue on an address match,
// otherwise they are fetched from memory with the same fixed latency.
module cache_writeback_buffer #(
    parameter int main_mem_size = 8388608,
    parameter int cache_block   = 512,
    parameter int depth         = 4,
    parameter int mem_latency   = 3,
    localparam int A            = $clog2(main_mem_size / cache_block)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cache_read_in,
    input  logic                   cache_write_in,
    input  logic [A-1:0]           cache_address_in,
    input  logic [cache_block-1:0] cache_data_in,
    input  logic                   flush_in,
    output logic [cache_block-1:0] cache_data_out,
    output logic                   data_valid_out,
    output logic                   busy_out,
    output logic                   mem_read_out,
    output logic                   mem_write_out,
    output logic [A-1:0]           mem_address_out,
    output logic [cache_block-1:0] mem_data_out,
    input  logic [cache_block-1:0] mem_data_in
);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam int LW = (mem_latency > 1) ? $clog2(mem_latency) : 1;
    localparam logic [CW-1:0] FULL     = CW'(depth);
    localparam logic [LW-1:0] LAT_INIT = LW'(mem_latency - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, FETCH} state_t;

    state_t                 state, state_nxt;
    logic [LW-1:0]          lat_cnt;
    logic [CW-1:0]          count, count_nxt;
    logic [PW-1:0]          head, tail;
    logic [depth-1:0]       valid;
    logic                   flush_flag, flush_nxt;

    logic [A-1:0]           addr_mem [depth];
    logic [cache_block-1:0] data_mem [depth];

    logic                   acc_wr, acc_rd;
    logic                   match;
    logic [PW-1:0]          match_idx;
    logic [cache_block-1:0] match_data;
    logic                   rd_hit;
    logic [cache_block-1:0] rd_data;

    // Requests are only taken while the buffer advertises room and is idle.
    assign acc_wr = cache_write_in && !busy_out;
    assign acc_rd = cache_read_in  && !busy_out;

    // Address search over the valid entries; coalescing keeps addresses unique.
    always_comb begin
        match      = 1'b0;
        match_idx  = '0;
        match_data = '0;
        for (int i = 0; i < depth; i++) begin
            if (valid[i] && (addr_mem[i] == cache_address_in)) begin
                match      = 1'b1;
                match_idx  = PW'(i);
                match_data = data_mem[i];
            end
        end
    end

    // Read and write share one address bus, so a same-cycle write always forwards.
    assign rd_hit  = acc_wr || match;
    assign rd_data = acc_wr ? cache_data_in : match_data;

    // Next-state, occupancy and flush flag; reads win over starting a drain, and
    // an accepted write also defers the drain so back-to-back evictions fill up.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flush_nxt = flush_flag;
        case (state)
            IDLE: begin
                if (acc_wr && !match) count_nxt = count + 1'b1;
                if (acc_rd && !rd_hit) state_nxt = FETCH;
                else if (!acc_rd && !acc_wr && (count != '0)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (lat_cnt == '0) begin
                    state_nxt = IDLE;
                    count_nxt = count - 1'b1;
                end
            end
            FETCH: begin
                if (lat_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_in) flush_nxt = 1'b1;
        else if (flush_flag && (state == IDLE) && (count == '0)) flush_nxt = 1'b0;
    end

    // Entry storage: overwrite on coalesce, otherwise fill the tail slot.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            if (match) begin
                data_mem[match_idx] <= cache_data_in;
            end else begin
                data_mem[tail] <= cache_data_in;
                addr_mem[tail] <= cache_address_in;
            end
        end
    end

    // Control state, FIFO bookkeeping and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            lat_cnt         <= '0;
            count           <= '0;
            head            <= '0;
            tail            <= '0;
            valid           <= '0;
            flush_flag      <= 1'b0;
            busy_out        <= 1'b0;
            data_valid_out  <= 1'b0;
            cache_data_out  <= '0;
            mem_read_out    <= 1'b0;
            mem_write_out   <= 1'b0;
            mem_address_out <= '0;
            mem_data_out    <= '0;
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            flush_flag     <= flush_nxt;
            busy_out       <= (state_nxt != IDLE) || (count_nxt == FULL) || flush_nxt;
            data_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc_wr && !match) begin
                        valid[tail] <= 1'b1;
                        tail        <= tail + 1'b1;
                    end
                    if (acc_rd && rd_hit) begin
                        cache_data_out <= rd_data;
                        data_valid_out <= 1'b1;
                    end else if (acc_rd) begin
                        mem_read_out    <= 1'b1;
                        mem_address_out <= cache_address_in;
                        lat_cnt         <= LAT_INIT;
                    end else if (state_nxt == DRAIN) begin
                        mem_write_out   <= 1'b1;
                        mem_address_out <= addr_mem[head];
                        mem_data_out    <= data_mem[head];
                        lat_cnt         <= LAT_INIT;
                    end
                end
                DRAIN: begin
                    if (lat_cnt == '0) begin
                        mem_write_out <= 1'b0;
                        valid[head]   <= 1'b0;
                        head          <= head + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                FETCH: begin
                    if (lat_cnt == '0) begin
                        mem_read_out   <= 1'b0;
                        cache_data_out <= mem_data_in;
                        data_valid_out <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Testbench for cache_writeback_buffer: directed scenarios plus randomized traffic,
// checked by a scoreboard against a queue-level model of the buffer contents.
module tb_cache_writeback_buffer;
    localparam int AW    = 14;
    localparam int BW    = 512;
    localparam int L     = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cache_read_in;
    logic          cache_write_in;
    logic [AW-1:0] cache_address_in;
    logic [BW-1:0] cache_data_in;
    logic          flush_in;
    logic [BW-1:0] cache_data_out;
    logic          data_valid_out;
    logic          busy_out;
    logic          mem_read_out;
    logic          mem_write_out;
    logic [AW-1:0] mem_address_out;
    logic [BW-1:0] mem_data_out;
    logic [BW-1:0] mem_data_in;

    cache_writeback_buffer #(
        .main_mem_size(8388608),
        .cache_block  (BW),
        .depth        (DEPTH),
        .mem_latency  (L)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cache_read_in   (cache_read_in),
        .cache_write_in  (cache_write_in),
        .cache_address_in(cache_address_in),
        .cache_data_in   (cache_data_in),
        .flush_in        (flush_in),
        .cache_data_out  (cache_data_out),
        .data_valid_out  (data_valid_out),
        .busy_out        (busy_out),
        .mem_read_out    (mem_read_out),
        .mem_write_out   (mem_write_out),
        .mem_address_out (mem_address_out),
        .mem_data_out    (mem_data_out),
        .mem_data_in     (mem_data_in)
    );

    typedef struct { logic [AW-1:0] addr; logic [BW-1:0] data; } ent_t;
    typedef struct { logic [BW-1:0] data; int due; bit miss; logic [AW-1:0] addr; } rexp_t;

    ent_t  mbuf[$];   // model: buffered blocks in drain order
    rexp_t rdq[$];    // expected read responses

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int total_writes = 0, total_reads = 0, write_cycles = 0, total_dv = 0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string nm, input logic [AW-1:0] a);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: address %0h, no such transaction expected (cycle %0d)", nm, a, cyc);
    endtask

    function automatic logic [BW-1:0] mem_pat(input logic [AW-1:0] a);
        logic [BW-1:0] p;
        for (int k = 0; k < BW / 32; k++) p[k*32 +: 32] = {a, 2'b10, 16'(k * 4099)} ^ 32'hC3A5_0F1E;
        return p;
    endfunction

    function automatic logic [BW-1:0] rand512();
        logic [BW-1:0] p;
        for (int k = 0; k < BW / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    // Monitor + memory responder: memory returns its data only in the last read cycle.
    initial begin
        int            wr_len, rd_len;
        bit            wr_unstable, rd_unstable;
        logic [AW-1:0] wr_a_h, rd_a_h;
        logic [BW-1:0] wr_d_h;
        ent_t          e;
        rexp_t         r;
        wr_len = 0; rd_len = 0; wr_unstable = 0; rd_unstable = 0;
        wr_a_h = '0; rd_a_h = '0; wr_d_h = '0;
        mem_data_in = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                wr_len = 0;
                rd_len = 0;
                mem_data_in = rand512();
            end else begin
                if (mem_read_out || mem_write_out)
                    check("rd_wr_exclusive", BW'(mem_read_out & mem_write_out), '0);
                if (mem_write_out) begin
                    if (wr_len == 0) begin
                        total_writes++;
                        wr_a_h = mem_address_out;
                        wr_d_h = mem_data_out;
                        wr_unstable = 0;
                        if (mbuf.size() == 0) fail_event("unexpected_mem_write", mem_address_out);
                        else begin
                            e = mbuf.pop_front();
                            check("drain_addr", BW'(mem_address_out), BW'(e.addr));
                            check("drain_data", mem_data_out, e.data);
                        end
                    end else if (mem_address_out !== wr_a_h || mem_data_out !== wr_d_h) begin
                        wr_unstable = 1;
                    end
                    wr_len++;
                    write_cycles++;
                end else if (wr_len != 0) begin
                    check("drain_len", BW'(wr_len), BW'(L));
                    check("drain_stable", BW'(wr_unstable), '0);
                    wr_len = 0;
                end
                if (mem_read_out) begin
                    if (rd_len == 0) begin
                        total_reads++;
                        rd_a_h = mem_address_out;
                        rd_unstable = 0;
                        if (rdq.size() == 0 || !rdq[0].miss) fail_event("unexpected_mem_read", mem_address_out);
                        else check("fetch_addr", BW'(mem_address_out), BW'(rdq[0].addr));
                    end else if (mem_address_out !== rd_a_h) begin
                        rd_unstable = 1;
                    end
                    rd_len++;
                    mem_data_in = (rd_len == L) ? mem_pat(mem_address_out) : rand512();
                end else begin
                    if (rd_len != 0) begin
                        check("fetch_len", BW'(rd_len), BW'(L));
                        check("fetch_stable", BW'(rd_unstable), '0);
                        rd_len = 0;
                    end
                    mem_data_in = rand512();
                end
                if (data_valid_out) begin
                    total_dv++;
                    if (rdq.size() == 0) fail_event("unexpected_data_valid", '0);
                    else begin
                        r = rdq.pop_front();
                        check("read_data", cache_data_out, r.data);
                        check("read_latency", BW'(cyc), BW'(r.due));
                    end
                end
            end
        end
    end

    // One cycle of stimulus; accepted requests update the model and expectations.
    task automatic cycle_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                             input logic [BW-1:0] d, input bit fl);
        bit    acc;
        int    idx;
        rexp_t r;
        acc = !busy_out && reset_n;
        cache_read_in    = rd;
        cache_write_in   = wr;
        cache_address_in = a;
        cache_data_in    = d;
        flush_in         = fl;
        if (acc && wr) begin
            idx = -1;
            foreach (mbuf[i]) if (mbuf[i].addr == a) idx = i;
            if (idx >= 0) mbuf[idx].data = d;
            else mbuf.push_back('{addr: a, data: d});
        end
        if (acc && rd) begin
            idx = -1;
            foreach (mbuf[i]) if (mbuf[i].addr == a) idx = i;
            r.addr = a;
            if (idx >= 0) begin
                r.data = mbuf[idx].data; r.due = cyc + 1; r.miss = 0;
            end else begin
                r.data = mem_pat(a); r.due = cyc + 1 + L; r.miss = 1;
            end
            rdq.push_back(r);
        end
        @(posedge clk);
        #1;
        cache_read_in  = 1'b0;
        cache_write_in = 1'b0;
        flush_in       = 1'b0;
    endtask

    task automatic idle1();
        cycle_req(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mbuf.size() != 0 || rdq.size() != 0 || busy_out || mem_write_out || mem_read_out) && n < 600) begin
            idle1();
            n++;
        end
        n_cmp++;
        if (n >= 600) begin
            n_bad++;
            $display("FAIL wait_idle: buffer not idle after %0d cycles", n);
        end
    endtask

    task automatic wait_write_start();
        for (int n = 0; n < 40 && !mem_write_out; n++) idle1();
        check("drain_started", BW'(mem_write_out), BW'(1));
    endtask

    initial begin
        logic [BW-1:0] d1, d2;
        int            w0, r0, dv0, wc0;
        reset_n = 1'b0;
        cache_read_in = 1'b0; cache_write_in = 1'b0; flush_in = 1'b0;
        cache_address_in = '0; cache_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", BW'(busy_out), '0);
        check("reset_dv", BW'(data_valid_out), '0);
        check("reset_mem_read", BW'(mem_read_out), '0);
        check("reset_mem_write", BW'(mem_write_out), '0);
        check("reset_cache_data", cache_data_out, '0);
        check("reset_mem_addr", BW'(mem_address_out), '0);
        check("reset_mem_data", mem_data_out, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Forwarding from a buffered entry
        d1 = rand512();
        r0 = total_reads;
        cycle_req(1'b0, 1'b1, 14'h0010, d1, 1'b0);
        cycle_req(1'b1, 1'b0, 14'h0010, '0, 1'b0);
        wait_idle();
        check("fwd_no_mem_read", BW'(total_reads - r0), '0);

        // Fill to full, then ordered drain
        for (int i = 1; i <= 4; i++) begin
            cycle_req(1'b0, 1'b1, AW'(i), rand512(), 1'b0);
            if (i == 3) check("busy_at_3", BW'(busy_out), '0);
            if (i == 4) check("busy_at_full", BW'(busy_out), BW'(1));
        end
        wait_write_start();
        for (int n = 0; n < 40 && mem_write_out; n++) idle1();
        check("busy_after_first_pop", BW'(busy_out), '0);
        wait_idle();

        // Coalesce
        d1 = rand512();
        d2 = rand512();
        w0 = total_writes;
        cycle_req(1'b0, 1'b1, 14'h0020, d1, 1'b0);
        cycle_req(1'b0, 1'b1, 14'h0020, d2, 1'b0);
        wait_idle();
        check("coalesce_one_write", BW'(total_writes - w0), BW'(1));

        // Read miss on empty buffer
        r0 = total_reads;
        cycle_req(1'b1, 1'b0, 14'h0100, '0, 1'b0);
        wait_idle();
        check("miss_one_fetch", BW'(total_reads - r0), BW'(1));

        // Read during drain is dropped, reissue is served
        cycle_req(1'b0, 1'b1, 14'h0030, rand512(), 1'b0);
        wait_write_start();
        check("busy_in_drain", BW'(busy_out), BW'(1));
        dv0 = total_dv;
        cycle_req(1'b1, 1'b0, 14'h0030, '0, 1'b0);
        for (int n = 0; n < 40 && busy_out; n++) idle1();
        cycle_req(1'b1, 1'b0, 14'h0030, '0, 1'b0);
        wait_idle();
        check("reissue_one_response", BW'(total_dv - dv0), BW'(1));

        // Flush with three entries
        for (int i = 0; i < 3; i++) cycle_req(1'b0, 1'b1, AW'(14'h0041 + i), rand512(), 1'b0);
        wc0 = write_cycles;
        cycle_req(1'b0, 1'b0, '0, '0, 1'b1);
        check("flush_busy", BW'(busy_out), BW'(1));
        for (int n = 0; n < 60 && busy_out; n++) idle1();
        check("flush_write_cycles", BW'(write_cycles - wc0), BW'(3 * L));
        check("flush_model_empty", BW'(mbuf.size()), '0);
        wait_idle();

        // Flush on empty buffer
        w0 = total_writes;
        cycle_req(1'b0, 1'b0, '0, '0, 1'b1);
        check("flush_empty_busy", BW'(busy_out), BW'(1));
        idle1();
        check("flush_empty_release", BW'(busy_out), '0);
        check("flush_empty_no_write", BW'(total_writes - w0), '0);

        // Reset in the middle of a drain
        cycle_req(1'b0, 1'b1, 14'h0051, rand512(), 1'b0);
        cycle_req(1'b0, 1'b1, 14'h0052, rand512(), 1'b0);
        wait_write_start();
        idle1();
        #2;
        reset_n = 1'b0;
        mbuf.delete();
        rdq.delete();
        #1;
        check("rst_mid_mem_write", BW'(mem_write_out), '0);
        check("rst_mid_busy", BW'(busy_out), '0);
        wc0 = total_writes;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) idle1();
        check("rst_no_more_writes", BW'(total_writes - wc0), '0);
        check("rst_idle_busy", BW'(busy_out), '0);

        // Randomized traffic over a small address set
        for (int it = 0; it < 600; it++) begin
            int            r;
            logic [AW-1:0] a;
            bit            rd, wr, fl;
            r  = $urandom_range(0, 9);
            a  = AW'($urandom_range(0, 7));
            rd = (r < 3) || (r == 9);
            wr = ((r >= 3) && (r <= 6)) || (r == 9);
            fl = (r == 7);
            if (busy_out && ($urandom_range(0, 3) != 0)) begin
                rd = 1'b0; wr = 1'b0; fl = 1'b0;
            end
            cycle_req(rd, wr, a, rand512(), fl);
        end
        wait_idle();
        repeat (3) idle1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
